axi4s_uart_tx: RTL and testbench

UART transmitter: accepts bytes on an AXI4-Stream slave handshake and serialises each as an asynchronous frame on `uart_txd` (start bit, 8 data bits LSB first, optional even parity, stop bit(s)). It is the transmit half of the `axi4s_uart` interface. It pairs with the existing receiver, which samples a fixed 8-bit frame. It sits between the byte-stream fabric and the FPGA TX pin.

---
 rtl/axi4s_uart_tx_if.sv | 9 +
 rtl/axi4s_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_axi4s_uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/axi4s_uart_tx_if.sv
// AXI4-Stream byte channel feeding the UART transmitter.
interface axi4s_uart_tx_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axi4s_uart_tx.sv
// UART transmitter: AXI4-Stream bytes in, 8-bit async frames out on uart_txd.
// Define AXI4S_UART_TX_PARITY_EN to add an even-parity bit; SYNTHESIS selects BAUD_RATE over BAUD_RATE_SIM.
module axi4s_uart_tx #(
    parameter real ACLK_FREQUENCY = 200000000.0,
    parameter int  BAUD_RATE      = 9600,
    parameter int  BAUD_RATE_SIM  = 50000000,
    parameter int  STOP_BITS      = 1
) (
    input  logic            aclk,
    input  logic            areset,
    axi4s_uart_tx_if.slave  tx_byte,
    output logic            uart_txd,
    output logic            tx_busy
);

    localparam int T_SYN = int'(ACLK_FREQUENCY / real'(BAUD_RATE));
    localparam int T_SIM = int'(ACLK_FREQUENCY / real'(BAUD_RATE_SIM));
`ifdef SYNTHESIS
    localparam int T = T_SYN;
`else
    localparam int T = T_SIM;
`endif
    localparam int            TW        = (T > 1) ? $clog2(T) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(T - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    // Both baud settings must give at least two clocks per bit.
    if (T_SYN < 2 || T_SIM < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("axi4s_uart_tx: clocks per bit must be >= 2 and STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef AXI4S_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          tready_q, tready_d;
`ifdef AXI4S_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic transfer;
    logic bit_done;

    assign transfer = tx_byte.tvalid && tready_q;
    assign bit_done = (tick_q == '0);

    // NOTE: sync reset has priority, so tvalid is ignored on any edge with areset high.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            tready_q  <= 1'b0;
`ifdef AXI4S_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere here so every flop samples the pre-edge values.
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            tready_q  <= tready_d;
`ifdef AXI4S_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next state and datapath; the tick counter reloads at every bit boundary.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef AXI4S_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    state_d   = S_START;
                    tick_d    = TICK_MAX;
                    bit_idx_d = '0;
                    shift_d   = tx_byte.tdata;
`ifdef AXI4S_UART_TX_PARITY_EN
                    parity_d  = ^tx_byte.tdata;
`endif
                end
            end
            S_START: begin
                tick_d = bit_done ? TICK_MAX : tick_q - 1'b1;
                if (bit_done) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                tick_d = bit_done ? TICK_MAX : tick_q - 1'b1;
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef AXI4S_UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef AXI4S_UART_TX_PARITY_EN
            S_PARITY: begin
                tick_d = bit_done ? TICK_MAX : tick_q - 1'b1;
                if (bit_done) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                tick_d = bit_done ? TICK_MAX : tick_q - 1'b1;
                if (bit_done) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = S_IDLE;
                        tick_d    = '0;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered one edge behind the state, keeping uart_txd glitch-free.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
`ifdef AXI4S_UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_q;
`endif
            default:  txd_d = 1'b1;
        endcase
        busy_d   = (state_q != S_IDLE) && (state_d != S_IDLE);
        tready_d = (state_d == S_IDLE);
    end

    assign uart_txd       = txd_q;
    assign tx_busy        = busy_q;
    assign tx_byte.tready = tready_q;

endmodule

// File: tb/tb_axi4s_uart_tx.sv
// Directed bench for axi4s_uart_tx at 200 MHz / 50 Mbaud (4 clocks per bit), 1 and 2 stop bits.
module tb_axi4s_uart_tx;

    localparam int T = 4;
`ifdef AXI4S_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F1 = 10 + P;
    localparam int F2 = 11 + P;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic txd1, busy1, txd2, busy2;
    int   checks = 0;
    int   failures = 0;

    axi4s_uart_tx_if if1 ();
    axi4s_uart_tx_if if2 ();

    axi4s_uart_tx #(
        .ACLK_FREQUENCY(200000000.0), .BAUD_RATE(9600), .BAUD_RATE_SIM(50000000), .STOP_BITS(1)
    ) dut1 (
        .aclk(aclk), .areset(areset), .tx_byte(if1), .uart_txd(txd1), .tx_busy(busy1)
    );

    axi4s_uart_tx #(
        .ACLK_FREQUENCY(200000000.0), .BAUD_RATE(9600), .BAUD_RATE_SIM(50000000), .STOP_BITS(2)
    ) dut2 (
        .aclk(aclk), .areset(areset), .tx_byte(if2), .uart_txd(txd2), .tx_busy(busy2)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Expected line level for frame bit k: start, LSB-first data, optional parity, stop(s).
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (P == 1 && k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] d);
        if (sel == 2) begin
            if2.tvalid = v;
            if2.tdata  = d;
        end else begin
            if1.tvalid = v;
            if1.tdata  = d;
        end
    endtask

    // Presents a byte while tready is high; returns just after the accepting edge N.
    task automatic start_xfer(input int sel, input logic [7:0] d, input bit hold);
        set_in(sel, 1'b1, d);
        check($sformatf("rdy%0d_pre_%02h", sel, d), (sel == 2) ? if2.tready : if1.tready, 1'b1);
        tick();
        check($sformatf("rdy%0d_acc_%02h", sel, d), (sel == 2) ? if2.tready : if1.tready, 1'b0);
        check($sformatf("busy%0d_acc_%02h", sel, d), (sel == 2) ? busy2 : busy1, 1'b0);
        check($sformatf("txd%0d_acc_%02h", sel, d), (sel == 2) ? txd2 : txd1, 1'b1);
        if (!hold) set_in(sel, 1'b0, d);
    endtask

    // Checks edges N+1 .. N+F*T of a frame already accepted at edge N.
    task automatic run_frame(input int sel, input logic [7:0] d, input bit toggle);
        int f;
        f = (sel == 2) ? F2 : F1;
        for (int c = 1; c <= f * T; c++) begin
            if (toggle) begin
                if (sel == 2) if2.tdata = 8'($urandom);
                else          if1.tdata = 8'($urandom);
            end
            tick();
            check($sformatf("txd%0d_%02h_c%0d", sel, d, c), (sel == 2) ? txd2 : txd1,
                  exp_bit(d, (c - 1) / T));
            check($sformatf("busy%0d_%02h_c%0d", sel, d, c), (sel == 2) ? busy2 : busy1,
                  (c < f * T) ? 1'b1 : 1'b0);
            check($sformatf("rdy%0d_%02h_c%0d", sel, d, c), (sel == 2) ? if2.tready : if1.tready,
                  (c == f * T) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        set_in(1, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);

        // Reset values
        areset = 1'b1;
        repeat (3) tick();
        check("rst_txd1", txd1, 1'b1);
        check("rst_busy1", busy1, 1'b0);
        check("rst_rdy1", if1.tready, 1'b0);
        check("rst_txd2", txd2, 1'b1);
        check("rst_rdy2", if2.tready, 1'b0);
        areset = 1'b0;
        tick();
        check("rel_rdy1", if1.tready, 1'b1);
        check("rel_rdy2", if2.tready, 1'b1);
        check("rel_busy1", busy1, 1'b0);

        // Single 0x55, then the parity-pattern bytes
        start_xfer(1, 8'h55, 1'b0);
        run_frame(1, 8'h55, 1'b0);
        tick();
        start_xfer(1, 8'h07, 1'b0);
        run_frame(1, 8'h07, 1'b0);
        start_xfer(1, 8'h03, 1'b0);
        run_frame(1, 8'h03, 1'b0);

        // Back-to-back with tvalid held: one idle-high cycle between frames
        start_xfer(1, 8'h00, 1'b1);
        run_frame(1, 8'h00, 1'b0);
        start_xfer(1, 8'hFF, 1'b0);
        run_frame(1, 8'hFF, 1'b0);

        // tvalid held with tdata toggling mid-frame
        start_xfer(1, 8'hA3, 1'b1);
        run_frame(1, 8'hA3, 1'b1);
        set_in(1, 1'b0, 8'h00);
        repeat (2) begin
            tick();
            check("bp_idle_busy1", busy1, 1'b0);
            check("bp_idle_txd1", txd1, 1'b1);
            check("bp_idle_rdy1", if1.tready, 1'b1);
        end

        // One-cycle reset during data bit 3, with tvalid asserted across it
        start_xfer(1, 8'hC6, 1'b0);
        for (int c = 1; c <= 4 * T + 2; c++) begin
            tick();
            check($sformatf("pre_rst_txd1_c%0d", c), txd1, exp_bit(8'hC6, (c - 1) / T));
        end
        areset = 1'b1;
        set_in(1, 1'b1, 8'hEE);
        tick();
        check("mid_rst_txd1", txd1, 1'b1);
        check("mid_rst_busy1", busy1, 1'b0);
        check("mid_rst_rdy1", if1.tready, 1'b0);
        areset = 1'b0;
        tick();
        check("post_rst_rdy1", if1.tready, 1'b1);
        check("post_rst_busy1", busy1, 1'b0);
        set_in(1, 1'b0, 8'h00);
        tick();
        check("post_rst_idle_busy1", busy1, 1'b0);
        check("post_rst_idle_txd1", txd1, 1'b1);
        start_xfer(1, 8'h3C, 1'b0);
        run_frame(1, 8'h3C, 1'b0);

        // Two stop bits, back-to-back
        start_xfer(2, 8'h96, 1'b1);
        run_frame(2, 8'h96, 1'b0);
        start_xfer(2, 8'h0F, 1'b0);
        run_frame(2, 8'h0F, 1'b0);
        tick();
        check("sb2_idle_txd2", txd2, 1'b1);
        check("sb2_idle_busy2", busy2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
